// File: rtl/frame_move_sched.sv
// Sequences one SDRAM frame move: selects the mux channels, settles them, raises a single
// frame request, waits for the matching finish (or a timeout) and reports completion.
module frame_move_sched #(
    parameter int unsigned     SETTLE_CYCLES = 4,
    parameter int unsigned     TO_W          = 24,
    parameter logic [TO_W-1:0] TIMEOUT       = 24'hFFFFFF
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_index,
    input  logic [31:0] cmd_bmp_addr,
    output logic [1:0]  write_ch,
    output logic [1:0]  read_ch,
    output logic [1:0]  sdram_index,
    output logic        bmp_read,
    output logic [31:0] bmp_read_addr,
    output logic        write_req,
    input  logic        write_req_ack,
    output logic        read_req,
    input  logic        read_req_ack,
    input  logic        write_finish,
    input  logic        read_finish,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [1:0]  disp_index,
    output logic [2:0]  state_dbg
);
    // Handshake: a command transfers on any clk_50 edge where cmd_valid and cmd_ready are both 1;
    // cmd_ready is only high in IDLE, so a source must hold its command until it is taken.
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [1:0]      OP_CAM   = 2'd0;
    localparam logic [1:0]      OP_LOAD  = 2'd1;
    localparam logic [1:0]      OP_SAVE  = 2'd2;
    localparam logic [1:0]      OP_DISP  = 2'd3;
    localparam logic [3:0]      SET_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      SET_PRE  = 4'(SETTLE_CYCLES - 2);
    localparam logic [TO_W-1:0] TO_LAST  = TIMEOUT - TO_W'(1);

    state_t          state_q;
    logic [1:0]      op_q;
    logic [3:0]      set_cnt_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            fin_q;
    logic [1:0]      write_ch_q, read_ch_q, sdram_index_q, disp_index_q;
    logic [31:0]     bmp_read_addr_q;
    logic            bmp_read_q, write_req_q, read_req_q, busy_q, done_q, err_q, cmd_ready_q;

    logic ack_now, fin_now, fin_any, to_hit;

    assign ack_now  = (op_q == OP_SAVE) ? read_req_ack : write_req_ack;
    assign fin_now  = (op_q == OP_SAVE) ? read_finish : write_finish;
    assign fin_any  = fin_q | fin_now;
    assign to_hit   = (to_cnt_q == TO_LAST);
    // Saturates so the counter can never wrap back into the live range.
    assign to_cnt_d = (to_cnt_q == TIMEOUT) ? to_cnt_q : to_cnt_q + TO_W'(1);

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            op_q            <= OP_CAM;
            set_cnt_q       <= '0;
            to_cnt_q        <= '0;
            fin_q           <= 1'b0;
            write_ch_q      <= 2'd0;
            read_ch_q       <= 2'd1;
            sdram_index_q   <= 2'd0;
            disp_index_q    <= 2'd0;
            bmp_read_addr_q <= '0;
            bmp_read_q      <= 1'b0;
            write_req_q     <= 1'b0;
            read_req_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            cmd_ready_q     <= 1'b1;
        end else begin
            bmp_read_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sdram_index_q <= disp_index_q;
                    read_ch_q     <= 2'd1;
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        fin_q       <= 1'b0;
                        err_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_op == OP_DISP) begin
                            disp_index_q <= cmd_index;
                            done_q       <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            sdram_index_q   <= cmd_index;
                            bmp_read_addr_q <= cmd_bmp_addr;
                            set_cnt_q       <= '0;
                            if (cmd_op == OP_CAM)  write_ch_q <= 2'd0;
                            if (cmd_op == OP_LOAD) write_ch_q <= 2'd1;
                            if (cmd_op == OP_SAVE) read_ch_q  <= 2'd0;
                            bmp_read_q <= (cmd_op == OP_LOAD) && (SETTLE_CYCLES == 1);
                            state_q    <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (set_cnt_q == SET_LAST) begin
                        to_cnt_q    <= '0;
                        write_req_q <= (op_q != OP_SAVE);
                        read_req_q  <= (op_q == OP_SAVE);
                        state_q     <= S_REQ;
                    end else begin
                        set_cnt_q  <= set_cnt_q + 4'd1;
                        // Registered pulse lands in the final settle cycle.
                        bmp_read_q <= (op_q == OP_LOAD) && (set_cnt_q == SET_PRE);
                    end
                end
                S_REQ: begin
                    to_cnt_q <= to_cnt_d;
                    if (fin_now) fin_q <= 1'b1;
                    if (to_hit && !(ack_now && fin_any)) begin
                        write_req_q <= 1'b0;
                        read_req_q  <= 1'b0;
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (ack_now) begin
                        write_req_q <= 1'b0;
                        read_req_q  <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    to_cnt_q <= to_cnt_d;
                    if (fin_any) begin
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    read_ch_q     <= 2'd1;
                    sdram_index_q <= disp_index_q;
                    busy_q        <= 1'b0;
                    cmd_ready_q   <= 1'b1;
                    err_q         <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign write_ch      = write_ch_q;
    assign read_ch       = read_ch_q;
    assign sdram_index   = sdram_index_q;
    assign bmp_read      = bmp_read_q;
    assign bmp_read_addr = bmp_read_addr_q;
    assign write_req     = write_req_q;
    assign read_req      = read_req_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_timeout   = err_q;
    assign disp_index    = disp_index_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_frame_move_sched.sv
// Bench for frame_move_sched: one unit with the full timeout and one with TIMEOUT=50,
// driven by directed and random transfers and checked against an outcome model.
module tb_frame_move_sched;
    localparam int S  = 4;
    localparam int T1 = 50;
    localparam int T0 = 24'hFFFFFF;

    // ---------------- clock / reset ----------------
    logic clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;
    logic rst;

    logic [1:0]  cmd_valid_v;
    logic [1:0]  cmd_op, cmd_index;
    logic [31:0] cmd_bmp_addr;
    logic        write_req_ack, read_req_ack, write_finish, read_finish;

    logic        cmd_ready_w [2];
    logic [1:0]  write_ch_w [2];
    logic [1:0]  read_ch_w [2];
    logic [1:0]  sdram_index_w [2];
    logic [1:0]  disp_index_w [2];
    logic        bmp_read_w [2];
    logic [31:0] bmp_addr_w [2];
    logic        write_req_w [2];
    logic        read_req_w [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        err_w [2];
    logic [2:0]  state_w [2];

    frame_move_sched #(.SETTLE_CYCLES(S), .TO_W(24), .TIMEOUT(24'hFFFFFF)) u_dut (
        .clk_50(clk_50), .rst(rst), .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_w[0]),
        .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_bmp_addr(cmd_bmp_addr),
        .write_ch(write_ch_w[0]), .read_ch(read_ch_w[0]), .sdram_index(sdram_index_w[0]),
        .bmp_read(bmp_read_w[0]), .bmp_read_addr(bmp_addr_w[0]),
        .write_req(write_req_w[0]), .write_req_ack(write_req_ack),
        .read_req(read_req_w[0]), .read_req_ack(read_req_ack),
        .write_finish(write_finish), .read_finish(read_finish),
        .busy(busy_w[0]), .done(done_w[0]), .err_timeout(err_w[0]),
        .disp_index(disp_index_w[0]), .state_dbg(state_w[0])
    );

    frame_move_sched #(.SETTLE_CYCLES(S), .TO_W(24), .TIMEOUT(24'd50)) u_dut_to (
        .clk_50(clk_50), .rst(rst), .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_w[1]),
        .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_bmp_addr(cmd_bmp_addr),
        .write_ch(write_ch_w[1]), .read_ch(read_ch_w[1]), .sdram_index(sdram_index_w[1]),
        .bmp_read(bmp_read_w[1]), .bmp_read_addr(bmp_addr_w[1]),
        .write_req(write_req_w[1]), .write_req_ack(write_req_ack),
        .read_req(read_req_w[1]), .read_req_ack(read_req_ack),
        .write_finish(write_finish), .read_finish(read_finish),
        .busy(busy_w[1]), .done(done_w[1]), .err_timeout(err_w[1]),
        .disp_index(disp_index_w[1]), .state_dbg(state_w[1])
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  wch_m [2];
    logic [1:0]  disp_m [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Outcome model, cycles counted from the first cycle the request is high (k = ack cycle,
    // f = matching finish cycle, tmo = timeout): when done shows, its error flag, request length.
    function automatic void model(input int k, input int f, input int tmo,
                                  output int rel, output bit err, output int req_n);
        if (k <= tmo - 1) begin
            req_n = k + 1;
            if (f <= k) begin rel = k + 2; err = 1'b0; end
            else if (k == tmo - 1) begin rel = tmo; err = 1'b1; end
            else if (f <= tmo - 1) begin rel = f + 1; err = 1'b0; end
            else begin rel = tmo; err = 1'b1; end
        end else begin
            req_n = tmo; rel = tmo; err = 1'b1;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic xfer(input int u, input logic [1:0] op, input logic [1:0] idx,
                        input logic [31:0] addr, input int k, input int f, input bit noise,
                        input bit hold, input logic [1:0] h_op, input logic [1:0] h_idx,
                        input logic [31:0] h_addr);
        int rel_e, req_e, c, done_c, first_req, req_n, bmp_n, rel;
        bit err_e, err_o, sel_bad, oth_bad, rdy_bad, nf, fin_m;
        logic mreq, oreq;
        logic [31:0] bmp_a;
        logic [1:0]  bmp_wch, e_wch, e_rch;
        model(k, f, (u == 1) ? T1 : T0, rel_e, err_e, req_e);
        exp_q.push_back(32'(rel_e));
        exp_q.push_back(32'(err_e));
        exp_q.push_back(32'(req_e));
        e_wch = (op == 2'd2) ? wch_m[u] : ((op == 2'd1) ? 2'd1 : 2'd0);
        e_rch = (op == 2'd2) ? 2'd0 : 2'd1;
        cmd_op = op; cmd_index = idx; cmd_bmp_addr = addr; cmd_valid_v[u] = 1'b1;
        tick();
        if (hold) begin
            cmd_op = h_op; cmd_index = h_idx; cmd_bmp_addr = h_addr;
        end else begin
            cmd_valid_v[u] = 1'b0;
        end
        c = 1; done_c = -1; first_req = -1; req_n = 0; bmp_n = 0; err_o = 1'b0;
        sel_bad = 1'b0; oth_bad = 1'b0; rdy_bad = 1'b0; bmp_a = '0; bmp_wch = 2'd3;
        while (c <= 400) begin
            if (write_ch_w[u] !== e_wch || read_ch_w[u] !== e_rch || sdram_index_w[u] !== idx)
                sel_bad = 1'b1;
            mreq = (op == 2'd2) ? read_req_w[u] : write_req_w[u];
            oreq = (op == 2'd2) ? write_req_w[u] : read_req_w[u];
            if (mreq === 1'b1) begin
                req_n++;
                if (first_req < 0) first_req = c;
            end
            if (oreq !== 1'b0) oth_bad = 1'b1;
            if (bmp_read_w[u] === 1'b1) begin
                bmp_n++; bmp_a = bmp_addr_w[u]; bmp_wch = write_ch_w[u];
            end
            if (cmd_ready_w[u] !== 1'b0 || busy_w[u] !== 1'b1) rdy_bad = 1'b1;
            if (done_w[u] === 1'b1) begin
                done_c = c; err_o = err_w[u];
                break;
            end
            rel = c - (S + 1);
            write_req_ack = (op != 2'd2) && (rel == k);
            read_req_ack  = (op == 2'd2) && (rel == k);
            fin_m = (rel == f);
            nf = noise && ($urandom_range(0, 2) == 0);
            write_finish = (op == 2'd2) ? nf : fin_m;
            read_finish  = (op == 2'd2) ? fin_m : nf;
            tick();
            c++;
        end
        write_req_ack = 1'b0; read_req_ack = 1'b0; write_finish = 1'b0; read_finish = 1'b0;
        check("done_cycle", 32'(done_c - (S + 1)), exp_q.pop_front());
        check("err_timeout", 32'(err_o), exp_q.pop_front());
        check("req_length", 32'(req_n), exp_q.pop_front());
        check("req_rise", 32'(first_req), 32'(S + 1));
        check("sel_hold", 32'(sel_bad), 32'd0);
        check("other_req", 32'(oth_bad), 32'd0);
        check("busy_ready", 32'(rdy_bad), 32'd0);
        check("bmp_pulses", 32'(bmp_n), (op == 2'd1) ? 32'd1 : 32'd0);
        if (op == 2'd1) begin
            check("bmp_addr", bmp_a, addr);
            check("bmp_write_ch", 32'(bmp_wch), 32'd1);
        end
        if (op != 2'd2) wch_m[u] = e_wch;
        tick();
        check("idle_read_ch", 32'(read_ch_w[u]), 32'd1);
        check("idle_sdram_index", 32'(sdram_index_w[u]), 32'(disp_m[u]));
        check("idle_ready", 32'(cmd_ready_w[u]), 32'd1);
        check("idle_done_low", 32'(done_w[u]), 32'd0);
    endtask

    task automatic display(input int u, input logic [1:0] idx);
        cmd_op = 2'd3; cmd_index = idx; cmd_valid_v[u] = 1'b1;
        tick();
        cmd_valid_v[u] = 1'b0;
        check("disp_done", 32'(done_w[u]), 32'd1);
        check("disp_err", 32'(err_w[u]), 32'd0);
        check("disp_index", 32'(disp_index_w[u]), 32'(idx));
        check("disp_ready", 32'(cmd_ready_w[u]), 32'd0);
        disp_m[u] = idx;
        tick();
        check("disp_done_low", 32'(done_w[u]), 32'd0);
        check("disp_sdram_index", 32'(sdram_index_w[u]), 32'(idx));
        check("disp_idle_ready", 32'(cmd_ready_w[u]), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit saw_done, saw_busy;
        rst = 1'b1; cmd_valid_v = 2'b00; cmd_op = 2'd0; cmd_index = 2'd0; cmd_bmp_addr = '0;
        write_req_ack = 1'b0; read_req_ack = 1'b0; write_finish = 1'b0; read_finish = 1'b0;
        wch_m[0] = 2'd0; wch_m[1] = 2'd0; disp_m[0] = 2'd0; disp_m[1] = 2'd0;
        repeat (3) tick();
        check("rst_write_ch", 32'(write_ch_w[0]), 32'd0);
        check("rst_read_ch", 32'(read_ch_w[0]), 32'd1);
        check("rst_sdram_index", 32'(sdram_index_w[0]), 32'd0);
        check("rst_disp_index", 32'(disp_index_w[0]), 32'd0);
        check("rst_bmp_addr", bmp_addr_w[0], 32'd0);
        check("rst_strobes", {27'd0, bmp_read_w[0], write_req_w[0], read_req_w[0], busy_w[0],
                              done_w[0]}, 32'd0);
        check("rst_err", 32'(err_w[0]), 32'd0);
        check("rst_ready", 32'(cmd_ready_w[0]), 32'd1);
        check("rst_state", 32'(state_w[0]), 32'd0);
        rst = 1'b0;
        tick();

        // Reset while an SD_LOAD request is pending.
        cmd_op = 2'd1; cmd_index = 2'd2; cmd_bmp_addr = 32'h1000; cmd_valid_v[0] = 1'b1;
        tick();
        cmd_valid_v[0] = 1'b0;
        repeat (S) tick();
        check("rst_pre_write_req", 32'(write_req_w[0]), 32'd1);
        write_req_ack = 1'b1; write_finish = 1'b1;
        #5 rst = 1'b1;
        #1;
        check("rst_mid_write_req", 32'(write_req_w[0]), 32'd0);
        check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
        check("rst_mid_read_ch", 32'(read_ch_w[0]), 32'd1);
        check("rst_mid_sdram_index", 32'(sdram_index_w[0]), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready_w[0]), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        write_req_ack = 1'b0; write_finish = 1'b0;
        saw_done = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_w[0] !== 1'b0) saw_done = 1'b1;
            if (busy_w[0] !== 1'b0) saw_busy = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        check("rst_stay_idle", 32'(saw_busy), 32'd0);

        // CAM_CAPTURE idx 1: ack 3 cycles after request, finish 100 cycles after ack.
        xfer(0, 2'd0, 2'd1, 32'h0, 3, 103, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        // SD_LOAD idx 2 with read_finish noise.
        xfer(0, 2'd1, 2'd2, 32'h0000_2000, 2, 30, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
        // SD_SAVE with ack but no finish on the short-timeout unit.
        xfer(1, 2'd2, 2'd1, 32'h0000_4000, 5, 1000, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
        // DISPLAY, then a CAM_CAPTURE with the next SD_LOAD held on cmd_valid while busy.
        display(0, 2'd3);
        xfer(0, 2'd0, 2'd0, 32'h0, 1, 8, 1'b0, 1'b1, 2'd1, 2'd1, 32'h0000_3000);
        xfer(0, 2'd1, 2'd1, 32'h0000_3000, 0, 5, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
        // Ack and finish in the same cycle.
        xfer(0, 2'd0, 2'd2, 32'h0, 6, 6, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        // Timeout boundaries on the short-timeout unit.
        xfer(1, 2'd0, 2'd3, 32'h0, 10, 49, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
        xfer(1, 2'd1, 2'd0, 32'h0000_0040, 49, 49, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        xfer(1, 2'd2, 2'd2, 32'h0000_0080, 49, 60, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0);
        xfer(1, 2'd0, 2'd1, 32'h0, 60, 5, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);

        for (int n = 0; n < 12; n++) begin
            xfer(1, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), $urandom,
                 int'($urandom_range(0, 55)), int'($urandom_range(0, 60)), 1'b1,
                 1'b0, 2'd0, 2'd0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_move_sched.md
Name: frame_move_sched

Overview:
- Command scheduler that sequences the SDRAM frame-move datapath: camera→SDRAM capture, SD→SDRAM bmp load, SDRAM→SD save, and SDRAM→HDMI display selection.
- Sits between the top-level control FSM and the frame-move mux/frame_read_write pair.
- Drives the channel selects, buffer index and bmp address, issues one frame transfer request, and waits for the matching finish.
- Holds the mux stable for the whole transfer and reports completion or timeout.

Parameters:
- SETTLE_CYCLES, 4: cycles the mux selects are held stable before a request is raised (1..15).
- TO_W, 24: width of the timeout counter.
- TIMEOUT, 24'hFFFFFF: cycles allowed from request assertion to finish before abort.

Ports:
- clk_50  in  1  system clock; all logic is on this clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command strobe; accepted when cmd_ready is 1.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0 = CAM_CAPTURE, 1 = SD_LOAD, 2 = SD_SAVE, 3 = DISPLAY.
- cmd_index  in  2  SDRAM frame buffer index.
- cmd_bmp_addr  in  32  SD bmp address, used by SD_LOAD and SD_SAVE.
- write_ch  out  2  write-port select: 0 = camera, 1 = SD.
- read_ch  out  2  read-port select: 0 = SD, 1 = video.
- sdram_index  out  2  buffer index driven to the mux.
- bmp_read  out  1  one-cycle pulse that starts an SD bmp read.
- bmp_read_addr  out  32  SD bmp address.
- write_req  out  1  write-frame request; level signal held until write_req_ack.
- write_req_ack  in  1  write request acknowledge.
- read_req  out  1  read-frame request; level signal held until read_req_ack.
- read_req_ack  in  1  read request acknowledge.
- write_finish  in  1  write frame complete; pulse, already synchronous to clk_50.
- read_finish  in  1  read frame complete; pulse, already synchronous to clk_50.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err_timeout  out  1  valid with done: 1 = the transfer timed out.
- disp_index  out  2  currently displayed buffer.

Behaviour:
- Reset values:
  - write_ch = 0, read_ch = 1, sdram_index = 0, disp_index = 0.
  - bmp_read_addr = 0.
  - bmp_read = 0, write_req = 0, read_req = 0, busy = 0, done = 0, err_timeout = 0.
  - cmd_ready = 1, state = IDLE.
- IDLE:
  - sdram_index = disp_index, read_ch = 1, write_ch holds its last value.
  - On cmd_valid & cmd_ready, latch op, index and address.
  - op = 3: disp_index ← cmd_index, then go to DONE (done appears 1 cycle after accept).
  - Any other op: go to SETUP.
- SETUP:
  - Drive the selects: CAM_CAPTURE write_ch = 0; SD_LOAD write_ch = 1; SD_SAVE read_ch = 0.
  - sdram_index = cmd_index, bmp_read_addr = cmd_bmp_addr.
  - Count SETTLE_CYCLES cycles, then go to REQ.
  - In SD_LOAD, bmp_read pulses in the last SETUP cycle.
- REQ:
  - Assert write_req (ops 0 and 1) or read_req (op 2).
  - Deassert the request in the cycle after the matching ack is sampled high, then go to WAIT.
  - The timeout counter starts at 0 on REQ entry and runs through REQ and WAIT.
- WAIT:
  - Wait for the matching finish: write_finish for ops 0/1, read_finish for op 2.
  - The non-matching finish is ignored.
- Finish capture and timeout:
  - A matching finish seen during REQ (same cycle as ack or earlier) is latched, and WAIT exits on its first cycle.
  - Counter reaching TIMEOUT in REQ or WAIT: drop the request, set err_timeout, go to DONE.
  - Finish and timeout in the same cycle: finish wins, err_timeout = 0.
- DONE:
  - done = 1 for exactly one cycle, with err_timeout valid.
  - Restore read_ch = 1 and sdram_index = disp_index; go to IDLE.
- Selects never change between SETUP entry and DONE.
- cmd_valid while busy is not accepted; the command must be held by the source.
- Only one of write_req / read_req is ever high.
- Timeout counter is TO_W bits, compared for equality, and never wraps.
- rst asserted mid-transfer: all outputs return to their reset values asynchronously, no done pulse, and a pending ack or finish is discarded.

Test Plan:
- Reset mid-SD_LOAD while write_req = 1 → write_req = 0, busy = 0, read_ch = 1, sdram_index = 0 immediately; no done pulse follows.
- CAM_CAPTURE, cmd_index = 1, ack 3 cycles after request, write_finish 100 cycles later:
  - write_ch = 0 and sdram_index = 1 from SETUP entry.
  - write_req rises 4 cycles later and falls the cycle after ack.
  - done = 1, err_timeout = 0 one cycle after the finish is sampled.
- SD_LOAD, index 2, bmp_addr = 32'h0000_2000:
  - bmp_read pulses exactly once with bmp_read_addr = 32'h2000 and write_ch = 1.
  - read_finish pulses are ignored; completion only on write_finish.
- SD_SAVE with TIMEOUT overridden to 50, ack given, no finish → read_req drops, done with err_timeout = 1 at cycle 50 after REQ entry; read_ch returns to 1.
- DISPLAY index 3, then cmd_valid held while busy on a following CAM_CAPTURE:
  - disp_index = 3, done one cycle after accept.
  - cmd_ready stays 0 until the CAM_CAPTURE done; the held second command is accepted in IDLE afterwards.
- Ack and write_finish in the same cycle → no wait in WAIT; done on the next cycle with err_timeout = 0.
